// File: rtl/seq_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Digit counter must hold the value D after the last increment.
  function automatic int cnt_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Request/result bundle between a requester and seq_addsub.
interface seq_addsub_if #(
  parameter int N = 16
);
  logic         start;
  logic         sub;
  logic         cin;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/seq_addsub_add_digit.sv
// Combinational W-bit adder slice; c_msb is the carry into the slice's top bit.
module add_digit #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] full;

  assign full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  assign s     = full[W-1:0];
  assign co    = full[W];
  // The top sum bit is x^y^carry_in, so the carry into it falls out by XOR.
  assign c_msb = x[W-1] ^ y[W-1] ^ s[W-1];
endmodule

// File: rtl/seq_addsub.sv
// Digit-serial N-bit adder/subtractor: W bits per clock, LSB digit first,
// with start/busy/done handshake and registered results.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_addsub_if.slave  bus
);
  localparam int             D    = N / W;
  localparam int             CW   = cnt_width(D);
  localparam logic [CW-1:0]  LAST = CW'(D - 1);

  if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
    $error("seq_addsub: N must be a positive multiple of W");
  end

  state_e          state_q, state_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    acc_shift;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [N-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    dig_s;
  logic            dig_co;
  logic            dig_cmsb;

  add_digit #(.W(W)) u_digit (
    .x     (op_a_q[W-1:0]),
    .y     (op_b_q[W-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digits enter at the top so the full result is aligned after D shifts.
  if (W == N) begin : g_single_digit
    assign acc_shift = dig_s;
  end else begin : g_multi_digit
    assign acc_shift = {dig_s, acc_q[N-1:W]};
  end

  // NOTE: combinational block assigns every target a default first, so no
  // path leaves a variable unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          op_a_d  = bus.a;
          // Subtraction is a + ~b + ~borrow_in.
          op_b_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        op_a_d  = op_a_q >> W;
        op_b_d  = op_b_q >> W;
        acc_d   = acc_shift;
        carry_d = dig_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_shift;
          cout_d  = dig_co;
          ovf_d   = dig_cmsb ^ dig_co;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub (N=16/W=4 and N=6/W=6) against an
// arithmetic reference model.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_addsub_if #(.N(16)) bus16 ();
  seq_addsub_if #(.N(6))  bus6 ();

  seq_addsub #(.N(16), .W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  seq_addsub #(.N(6),  .W(6)) dut6  (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_sum = '0;
  logic [5:0]  last_sum6 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, ovf, sum[15:0]} from plain integer arithmetic on n bits.
  function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    longint m, ua, ub, sa, sb, r, sr, c;
    logic   co, ov;
    m  = longint'(1) << n;
    c  = longint'(cin);
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sub ? ua - ub - c : ua + ub + c;
    sr = sub ? sa - sb - c : sa + sb + c;
    co = sub ? (r >= 0) : (r >= m);
    ov = (sr >= m / 2) || (sr < -(m / 2));
    r  = ((r % m) + m) % m;
    return {co, ov, 16'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse; returns one step after the accepting edge T0.
  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic sub, input logic cin);
    bus16.a = a; bus16.b = b; bus16.sub = sub; bus16.cin = cin; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    bus16.sub = 1'($urandom); bus16.cin = 1'($urandom);
  endtask

  // Waits for done (bounded); optionally re-pulses start while busy.
  task automatic finish16(input string tag, input logic [17:0] exp, input int repulse_at);
    int cyc = 0;
    int busy_cnt = 0;
    while (!bus16.done && cyc < 20) begin
      if (bus16.busy) busy_cnt++;
      check({tag, "_held"}, bus16.sum, last_sum);
      bus16.start = (cyc == repulse_at);
      tick();
      bus16.start = 1'b0;
      cyc++;
    end
    check({tag, "_lat"},  cyc, 4);
    check({tag, "_busy"}, busy_cnt, 4);
    check({tag, "_sum"},  bus16.sum,  exp[15:0]);
    check({tag, "_cout"}, bus16.cout, exp[17]);
    check({tag, "_ovf"},  bus16.ovf,  exp[16]);
    check({tag, "_busy_at_done"}, bus16.busy, 1'b0);
    last_sum = exp[15:0];
  endtask

  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin);
    logic [17:0] exp;
    exp = model(16, a, b, sub, cin);
    launch16(a, b, sub, cin);
    finish16(tag, exp, -1);
    tick();
    check({tag, "_done_fall"}, bus16.done, 1'b0);
  endtask

  task automatic op6(input string tag, input logic [5:0] a, input logic [5:0] b,
                     input logic sub, input logic cin);
    logic [17:0] exp;
    int cyc = 0;
    exp = model(6, {10'b0, a}, {10'b0, b}, sub, cin);
    bus6.a = a; bus6.b = b; bus6.sub = sub; bus6.cin = cin; bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    check({tag, "_busy"}, bus6.busy, 1'b1);
    check({tag, "_held"}, bus6.sum, last_sum6);
    while (!bus6.done && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_lat"},  cyc, 1);
    check({tag, "_sum"},  bus6.sum,  exp[5:0]);
    check({tag, "_cout"}, bus6.cout, exp[17]);
    check({tag, "_ovf"},  bus6.ovf,  exp[16]);
    last_sum6 = exp[5:0];
    tick();
    check({tag, "_done_fall"}, bus6.done, 1'b0);
  endtask

  initial begin
    logic [17:0] exp1, exp2;
    logic [15:0] ra, rb;
    logic        rs, rc;
    int          saw_done;

    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;
    bus6.start  = 1'b0; bus6.sub  = 1'b0; bus6.cin  = 1'b0; bus6.a  = '0; bus6.b  = '0;
    repeat (3) tick();
    check("rst_busy", bus16.busy, 1'b0);
    check("rst_done", bus16.done, 1'b0);
    check("rst_sum",  bus16.sum,  16'h0000);
    check("rst_cout", bus16.cout, 1'b0);
    check("rst_ovf",  bus16.ovf,  1'b0);
    check("rst6_sum", bus6.sum,   6'h00);
    rst_n = 1'b1;
    tick();
    check("idle_busy", bus16.busy, 1'b0);

    // Directed cases from the arithmetic corners.
    op16("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    check("add1_const", bus16.sum, 16'h2233);
    op16("sub0", 16'h0005, 16'h0007, 1'b1, 1'b0);
    check("sub0_const", bus16.sum, 16'hFFFE);
    op16("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1);
    check("sub1_const", bus16.sum, 16'hFFFD);
    op16("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("ovf_flag", bus16.ovf, 1'b1);
    op16("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    check("wrap_cout", bus16.cout, 1'b1);
    op16("subovf", 16'h8000, 16'h0001, 1'b1, 1'b0);

    // start during busy is ignored and not queued.
    exp1 = model(16, 16'hABCD, 16'h1111, 1'b0, 1'b1);
    launch16(16'hABCD, 16'h1111, 1'b0, 1'b1);
    finish16("repulse", exp1, 1);
    tick();
    check("repulse_no_queue", bus16.busy, 1'b0);

    // start held in the done cycle: back-to-back without a bubble.
    exp1 = model(16, 16'h4321, 16'h0F0F, 1'b0, 1'b0);
    exp2 = model(16, 16'h1000, 16'h2345, 1'b1, 1'b1);
    launch16(16'h4321, 16'h0F0F, 1'b0, 1'b0);
    finish16("b2b_first", exp1, -1);
    bus16.a = 16'h1000; bus16.b = 16'h2345; bus16.sub = 1'b1; bus16.cin = 1'b1;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check("b2b_done_fall", bus16.done, 1'b0);
    check("b2b_busy",      bus16.busy, 1'b1);
    finish16("b2b_second", exp2, -1);
    tick();

    // Asynchronous reset in the second RUN cycle aborts the operation.
    launch16(16'h5555, 16'h3333, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus16.busy, 1'b0);
    check("arst_done", bus16.done, 1'b0);
    check("arst_sum",  bus16.sum,  16'h0000);
    check("arst_cout", bus16.cout, 1'b0);
    check("arst_ovf",  bus16.ovf,  1'b0);
    tick();
    rst_n = 1'b1;
    last_sum = '0;
    saw_done = 0;
    repeat (8) begin
      tick();
      if (bus16.done) saw_done++;
    end
    check("arst_no_done", saw_done, 0);
    check("arst_sum_kept", bus16.sum, 16'h0000);
    op16("post_rst", 16'h00FF, 16'h0101, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      op16("rand", ra, rb, rs, rc);
    end

    // Single-digit configuration (D=1).
    op6("d1_wrap", 6'h3F, 6'h01, 1'b0, 1'b0);
    check("d1_wrap_const", bus6.sum, 6'h00);
    check("d1_wrap_cout",  bus6.cout, 1'b1);
    for (int i = 0; i < 8; i++) begin
      op6("d1_rand", 6'($urandom), 6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
